// File: rtl/fp6_pkg.sv
// fp6_pkg
//   Shared constants and types for the 6-bit floating-point multiplier
//   scheduler. The word layout is sign[5], exponent[4:1] (biased by BIAS),
//   mantissa[0] with an implicit leading one.
//   No ports; imported by fp6_mul_core and fp_mul_rr_scheduler.
package fp6_pkg;

  localparam int N      = 6;
  localparam int E      = 4;
  localparam int MA     = 1;
  localparam int BIAS   = 7;
  localparam int SIGN   = 5;
  localparam int EXP_HI = 4;
  localparam int EXP_LO = 1;

  // RUN grants requests, DRAIN lets the pipeline empty, HALT parks it idle.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/fp6_mul_core.sv
// fp6_mul_core
//   Purely combinational 6-bit floating-point multiplier.
//   Ports:
//     a, b : operands, {sign, exp[3:0], mantissa}
//     y    : product, same format
//   Exponent wraps modulo 16. No overflow, underflow, zero or infinity handling.
module fp6_mul_core import fp6_pkg::*; #(
  parameter int EXP_BIAS = BIAS
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);

  logic [3:0] p_raw;
  logic [3:0] p;
  logic       sticky;
  logic       nrm;
  logic       m;
  logic [3:0] e;

  // Multiply the two 2-bit significands {1,m}. The product lies in 4..9.
  // Bit 3 set means the product is >= 2.0, and the exponent gains one.
  // Otherwise the product is shifted left so the leading one sits in bit 3.
  // Rounding is a single add of guard & (round | sticky) to the kept bit.
  // The carry out of that add is dropped.
  // The LSB of the unshifted product acts as the sticky bit.
  always_comb begin
    p_raw  = {2'b00, 1'b1, a[0]} * {2'b00, 1'b1, b[0]};
    sticky = p_raw[0];
    nrm    = p_raw[3];
    p      = nrm ? p_raw : {p_raw[2:0], 1'b0};
    m      = p[2] ^ (p[1] & (p[0] | sticky));
    e      = a[EXP_HI:EXP_LO] + b[EXP_HI:EXP_LO] - 4'(EXP_BIAS) + {3'b000, nrm};
    y      = {a[SIGN] ^ b[SIGN], e, m};
  end

endmodule

// File: rtl/fp_mul_rr_scheduler.sv
// fp_mul_rr_scheduler
//   Shares one fp6_mul_core between NREQ requesters. Requests are granted
//   round-robin into a two-stage pipeline: an operand register, then a
//   result register. Latency is 2 cycles and throughput is 1 op per cycle.
//   A flush/drain FSM empties the pipeline and then parks it in HALT.
//   Ports:
//     clk, rst            : clock and synchronous active-high reset
//     req_valid/req_ready : per-requester handshake (req_ready is one-hot or zero)
//     req_a, req_b        : packed operands, requester i at [i*N +: N]
//     flush               : level request to drain and halt
//     halted              : high only while in HALT
//     busy                : any pipeline stage holds a valid op
//     rsp_valid/id/y      : one-cycle result pulse with the requester index
module fp_mul_rr_scheduler import fp6_pkg::*; #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int N    = 6,
  parameter int BIAS = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  input  logic              flush,
  output logic              halted,
  output logic              busy,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_y
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic             s1_valid_q, s1_valid_d;
  logic [N-1:0]     s1_a_q, s1_a_d;
  logic [N-1:0]     s1_b_q, s1_b_d;
  logic [IDW-1:0]   s1_id_q, s1_id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [N-1:0]     rsp_y_q, rsp_y_d;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_id;
  logic             grant_any;
  logic [N-1:0]     core_y;

  fp6_mul_core #(.EXP_BIAS(BIAS)) u_core (
    .a (s1_a_q),
    .b (s1_b_q),
    .y (core_y)
  );

  // Round-robin arbiter: find the first valid requester, starting at the
  // pointer and wrapping around. A raised flush blocks the grant at once,
  // even before the FSM has left RUN.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    if (state_q == RUN && !flush) begin
      for (int off = 0; off < NREQ; off++) begin
        idx = int'(ptr_q) + off;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!grant_any && req_valid[idx]) begin
          grant_any     = 1'b1;
          grant_id      = IDW'(idx);
          grant[idx]    = 1'b1;
        end
      end
    end
  end

  // After a grant, the pointer moves to the requester just past the winner.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_any) begin
      ptr_d = (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
    end
  end

  // DRAIN may leave as soon as stage 1 is empty. The response stage cannot
  // stall, so it is also empty after this same edge. HALT therefore always
  // means an empty pipeline.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (flush)       state_d = DRAIN;
      DRAIN:   if (!s1_valid_q) state_d = HALT;
      HALT:    if (!flush)      state_d = RUN;
      default:                  state_d = RUN;
    endcase
  end

  // Pipeline: stage 1 captures the granted operands. The response stage
  // captures the core output. Data registers load only behind a valid bit.
  always_comb begin
    s1_valid_d  = grant_any;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_id_d     = s1_id_q;
    rsp_valid_d = s1_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_y_d     = rsp_y_q;
    if (grant_any) begin
      s1_a_d  = req_a[int'(grant_id)*N +: N];
      s1_b_d  = req_b[int'(grant_id)*N +: N];
      s1_id_d = grant_id;
    end
    if (s1_valid_q) begin
      rsp_id_d = s1_id_q;
      rsp_y_d  = core_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      ptr_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_id_q     <= s1_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_y_q     <= rsp_y_d;
    end
  end

  assign req_ready = grant;
  assign halted    = (state_q == HALT);
  assign busy      = s1_valid_q | rsp_valid_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_y     = rsp_y_q;

endmodule
